johnson_phase_monitor: RTL and testbench

Registered consumer of the 4-bit Johnson (twisted-ring) counter outputs {A,B,C,E}, clocked on the same `clk`/`rstn` as the counter. Per cycle it:
- decodes the counter state into eight one-hot timing phases and a 3-bit phase index;
- flags any of the eight unused (illegal) counter states;
- checks every step is a legal successor;
- counts completed revolutions.

It sits directly downstream of the counter and supplies timing strobes and health status to the control logic.

---
 rtl/johnson_phase_monitor_pkg.sv | 23 ++
 rtl/johnson_phase_decode.sv | 40 ++++
 rtl/johnson_phase_monitor.sv | 73 +++++++
 tb/tb_johnson_phase_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/johnson_phase_monitor_pkg.sv
// rtl/johnson_phase_monitor_pkg.sv - shared constants and helpers for the Johnson phase monitor
package johnson_phase_monitor_pkg;

  localparam int JPH_W = 3;

  // Counter states {A,B,C,E} in phase order
  localparam logic [3:0] JS_P0 = 4'b0000;
  localparam logic [3:0] JS_P1 = 4'b1000;
  localparam logic [3:0] JS_P2 = 4'b1100;
  localparam logic [3:0] JS_P3 = 4'b1110;
  localparam logic [3:0] JS_P4 = 4'b1111;
  localparam logic [3:0] JS_P5 = 4'b0111;
  localparam logic [3:0] JS_P6 = 4'b0011;
  localparam logic [3:0] JS_P7 = 4'b0001;

  // A legal twisted-ring state has at most one boundary between adjacent bits
  function automatic logic jc_legal(input logic [3:0] j);
    logic [2:0] t;
    t = {j[3] ^ j[2], j[2] ^ j[1], j[1] ^ j[0]};
    return ((t & (t - 3'd1)) == 3'd0);
  endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// rtl/johnson_phase_decode.sv - combinational legality, one-hot and index decode of a Johnson state
module johnson_phase_decode
  import johnson_phase_monitor_pkg::*;
(
  input  logic [3:0]       j,
  output logic             legal,
  output logic [7:0]       phase_oh,
  output logic [JPH_W-1:0] idx
);

  logic a, b, c, e;
  logic [7:0] raw;

  assign a = j[3];
  assign b = j[2];
  assign c = j[1];
  assign e = j[0];

  assign legal = jc_legal(j);

  // Two-input terms only decode correctly for legal states, hence the qualification
  assign raw = {~c & e, ~b & c, ~a & b, a & e, c & ~e, b & ~c, a & ~b, ~a & ~e};
  assign phase_oh = legal ? raw : 8'h00;

  always_comb begin
    idx = '0;
    case (j)
      JS_P0:   idx = JPH_W'(0);
      JS_P1:   idx = JPH_W'(1);
      JS_P2:   idx = JPH_W'(2);
      JS_P3:   idx = JPH_W'(3);
      JS_P4:   idx = JPH_W'(4);
      JS_P5:   idx = JPH_W'(5);
      JS_P6:   idx = JPH_W'(6);
      JS_P7:   idx = JPH_W'(7);
      default: idx = '0;
    endcase
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// rtl/johnson_phase_monitor.sv - registered phase strobes, sequence health and revolution count
module johnson_phase_monitor
  import johnson_phase_monitor_pkg::*;
#(
  parameter int REV_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       j,
  input  logic             clr_err,
  output logic [7:0]       phase,
  output logic [JPH_W-1:0] phase_idx,
  output logic             illegal,
  output logic             seq_err,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_count,
  output logic             err_sticky
);

  logic             dec_legal;
  logic [7:0]       dec_oh;
  logic [JPH_W-1:0] dec_idx;
  logic [JPH_W-1:0] prev_idx;
  logic             prev_valid;
  logic             chk, step_ok, seq_nxt, tick_nxt, ill_nxt;

  johnson_phase_decode u_decode (
    .j        (j),
    .legal    (dec_legal),
    .phase_oh (dec_oh),
    .idx      (dec_idx)
  );

  always_comb begin
    chk      = dec_legal & prev_valid;
    step_ok  = (dec_idx == prev_idx) || (dec_idx == prev_idx + JPH_W'(1));
    seq_nxt  = chk & ~step_ok;
    tick_nxt = chk && (dec_idx == '0) && (prev_idx == '1);
    ill_nxt  = ~dec_legal;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase      <= 8'h01;
      phase_idx  <= '0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      rev_tick   <= 1'b0;
      rev_count  <= '0;
      err_sticky <= 1'b0;
      prev_idx   <= '0;
      prev_valid <= 1'b0;
    end else begin
      illegal  <= ill_nxt;
      seq_err  <= seq_nxt;
      rev_tick <= tick_nxt;
      // phase_idx holds across an illegal sample; phase goes dark
      if (dec_legal) begin
        phase      <= dec_oh;
        phase_idx  <= dec_idx;
        prev_idx   <= dec_idx;
        prev_valid <= 1'b1;
      end else begin
        phase      <= 8'h00;
        prev_valid <= 1'b0;
      end
      if (tick_nxt) rev_count <= rev_count + REV_W'(1);
      // A new error outranks a simultaneous clear
      err_sticky <= ill_nxt | seq_nxt | (err_sticky & ~clr_err);
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb/tb_johnson_phase_monitor.sv - self-checking bench for johnson_phase_monitor
module tb_johnson_phase_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] j;
  logic       clr_err;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       illegal, seq_err, rev_tick, err_sticky;
  logic [7:0] rev_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] phase;
    logic [2:0] idx;
    logic       ill;
    logic       seq;
    logic       tick;
    logic [7:0] cnt;
    logic       sticky;
  } exp_t;

  typedef struct {
    logic [3:0] j;
    logic       clr;
    logic [7:0] phase;
    logic [2:0] idx;
    logic       ill;
    logic       seq;
    logic       tick;
    logic [7:0] cnt;
    logic       sticky;
  } vec_t;

  exp_t sb[$];
  exp_t none;
  vec_t tv1[9];
  vec_t tv3[2];
  logic [3:0] jmap[8];

  int         m_pi, m_cnt, m_idx;
  bit         m_pv, m_sticky;
  logic [7:0] m_phase;

  johnson_phase_monitor #(.REV_W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .j          (j),
    .clr_err    (clr_err),
    .phase      (phase),
    .phase_idx  (phase_idx),
    .illegal    (illegal),
    .seq_err    (seq_err),
    .rev_tick   (rev_tick),
    .rev_count  (rev_count),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pi = 0; m_cnt = 0; m_idx = 0; m_pv = 0; m_sticky = 0; m_phase = 8'h01;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_phase"}, int'(phase), 1);
    chk({tag, "_idx"}, int'(phase_idx), 0);
    chk({tag, "_flags"}, int'({illegal, seq_err, rev_tick, err_sticky}), 0);
    chk({tag, "_count"}, int'(rev_count), 0);
  endtask

  task automatic model(input logic [3:0] jv, input logic cv, output exp_t me);
    int  f;
    bit  ill, seq, tick, c;
    f = -1;
    for (int k = 0; k < 8; k++) if (jmap[k] == jv) f = k;
    seq = 0; tick = 0;
    if (f >= 0) begin
      c    = m_pv;
      seq  = c && !(f == m_pi || f == ((m_pi + 1) % 8));
      tick = c && f == 0 && m_pi == 7;
      m_phase = 8'h01 << f;
      m_idx = f; m_pi = f; m_pv = 1; ill = 0;
      if (tick) m_cnt = (m_cnt + 1) % 256;
    end else begin
      m_phase = 8'h00; ill = 1; m_pv = 0;
    end
    m_sticky = ill | seq | (m_sticky & !cv);
    me = '{m_phase, 3'(m_idx), ill, seq, tick, 8'(m_cnt), m_sticky};
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("phase", int'(phase), int'(e.phase));
    chk("phase_idx", int'(phase_idx), int'(e.idx));
    chk("illegal", int'(illegal), int'(e.ill));
    chk("seq_err", int'(seq_err), int'(e.seq));
    chk("rev_tick", int'(rev_tick), int'(e.tick));
    chk("rev_count", int'(rev_count), int'(e.cnt));
    chk("err_sticky", int'(err_sticky), int'(e.sticky));
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic drive(input logic [3:0] jv, input logic cv, input bit tab, input exp_t te);
    exp_t me;
    j = jv; clr_err = cv;
    model(jv, cv, me);
    sb.push_back(tab ? te : me);
    @(posedge clk); #1;
    compare();
    @(negedge clk);
  endtask

  function automatic exp_t v2e(input vec_t v);
    return '{v.phase, v.idx, v.ill, v.seq, v.tick, v.cnt, v.sticky};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    jmap = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    none = '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tv1[0] = '{4'b0000, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tv1[1] = '{4'b1000, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tv1[2] = '{4'b1100, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tv1[3] = '{4'b1110, 1'b0, 8'h08, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tv1[4] = '{4'b1111, 1'b0, 8'h10, 3'd4, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tv1[5] = '{4'b0111, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tv1[6] = '{4'b0011, 1'b0, 8'h40, 3'd6, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tv1[7] = '{4'b0001, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tv1[8] = '{4'b0000, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0};
    tv3[0] = '{4'b1010, 1'b0, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0, 8'd13, 1'b1};
    tv3[1] = '{4'b1100, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 8'd13, 1'b1};

    rstn = 1'b0; j = 4'b0000; clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset("reset");

    // Release and one full revolution
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 9; i++) drive(tv1[i].j, tv1[i].clr, 1'b1, v2e(tv1[i]));

    // Free run: 100 steps -> 12 more wraps
    for (int k = 1; k <= 100; k++) drive(jmap[k % 8], 1'b0, 1'b0, none);
    chk("free_run_count", int'(rev_count), 13);

    // Illegal state then unchecked recovery
    for (int i = 0; i < 2; i++) drive(tv3[i].j, tv3[i].clr, 1'b1, v2e(tv3[i]));

    // Walk to idx 1, jump to idx 4, then hold
    for (int k = 3; k <= 9; k++) drive(jmap[k % 8], 1'b0, 1'b0, none);
    drive(4'b1111, 1'b0, 1'b0, none);
    chk("jump_seq_err", int'(seq_err), 1);
    drive(4'b1111, 1'b0, 1'b0, none);
    drive(4'b1111, 1'b0, 1'b0, none);
    chk("hold_no_err", int'({seq_err, illegal, rev_tick}), 0);

    // Clear vs. simultaneous set
    drive(4'b1111, 1'b1, 1'b0, none);
    chk("clr_alone", int'(err_sticky), 0);
    drive(4'b1000, 1'b1, 1'b0, none);
    chk("set_beats_clr", int'(err_sticky), 1);
    drive(4'b1000, 1'b1, 1'b0, none);
    chk("clr_after", int'(err_sticky), 0);

    // Advance to phase 5 then async reset mid-cycle
    for (int k = 2; k <= 5; k++) drive(jmap[k], 1'b0, 1'b0, none);
    #2;
    rstn = 1'b0; j = 4'b0000; clr_err = 1'b0;
    #1 check_reset("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset("reset_held");
    @(negedge clk);
    rstn = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, none);
    drive(4'b1000, 1'b0, 1'b0, none);
    chk("post_reset_clean", int'({seq_err, illegal, rev_tick, err_sticky}), 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
